rv32_mc_control: RTL and testbench
==================================

# rv32_mc_control

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back states over a shared single-port memory. It drives the enables and mux selects for the PC, IR, register file, ALU operand B and memory port. The immediate generator, ALU and register file stay purely combinational and are sequenced entirely by this block.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  IR[6:0]; valid from DECODE onward.
- `branch_taken`  in  1  branch comparator result; sampled in EXEC only.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_addr_sel`  out  1  address source: 0 = PC, 1 = ALU result.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  load PC.
- `pc_src`  out  2  next-PC source: 0 = PC+4, 1 = PC+Imm, 2 = (rs1+Imm)&~1.
- `alu_b_imm`  out  1  ALU operand B: 1 = Imm, 0 = rs2.
- `reg_write`  out  1  register file write enable.
- `wb_sel`  out  2  write-back source: 0 = ALU, 1 = mem data, 2 = PC+4, 3 = Imm.
- `state`  out  3  current state encoding, for debug.
- `halted`  out  1  core is stopped in HALT.
- `instret`  out  32  count of retired instructions.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to FETCH on the next clock.
- **Opcode latch:** `opcode` is latched into an internal register at the DECODE edge. EXEC, MEM and WB decode only the latched copy.
- **Opcode classes:**
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
  - BRANCH 1100011
  - LOAD 0000011
  - STORE 0100011
  - OPIMM 0010011
  - OP 0110011
  - FENCE 0001111
  - SYSTEM 1110011
  - Any other value is ILLEGAL.
- **FETCH:**
  - `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - Hold until `mem_ready`. In the `mem_ready` cycle, `ir_write`=1, then go to DECODE.
- **DECODE:** SYSTEM or ILLEGAL goes to HALT. All other classes go to EXEC.
- **EXEC:**
  - `alu_b_imm`=1 for every class except OP and BRANCH.
  - BRANCH: `pc_write`=1, `pc_src`=1 if `branch_taken` else 0; retire; go to FETCH.
  - FENCE: `pc_write`=1, `pc_src`=0; retire; go to FETCH.
  - LOAD and STORE go to MEM. All other classes go to WB.
- **MEM:**
  - `mem_req`=1, `mem_addr_sel`=1, `alu_b_imm`=1, `mem_we`=1 for STORE only.
  - Hold until `mem_ready`.
  - STORE then sets `pc_write`=1, `pc_src`=0, retires, and goes to FETCH. LOAD goes to WB.
- **WB:** `reg_write`=1 and `pc_write`=1, retire, go to FETCH. Selects by class:
  - OP and OPIMM: `wb_sel`=0.
  - LOAD: `wb_sel`=1.
  - JAL: `wb_sel`=2, `pc_src`=1.
  - JALR: `wb_sel`=2, `pc_src`=2.
  - LUI: `wb_sel`=3.
  - AUIPC: `wb_sel`=0 with the ALU adding PC+Imm.
  - `pc_src`=0 for every class except JAL and JALR.
- **HALT:** absorbing state. All enables are 0 and `halted`=1. Only `rst` leaves HALT.
- **Retire:** `instret` increments by 1 on the edge that completes an instruction. Wraps 0xFFFFFFFF → 0 with no flag.
- **Output defaults:** every output not listed for a state is 0.

## Timing
- **Output logic:** all outputs are combinational from `state`, the latched opcode, `mem_ready` and `branch_taken`. Registered elements are `state`, the opcode latch and `instret`.
- **Reset values:** `state`=FETCH, opcode latch=0, `instret`=0, `halted`=0. Since `state`=FETCH, `mem_req`=1 during and after reset; all other enables are 0.
- **Latency with zero wait states:**
  - BRANCH, FENCE: 3 cycles.
  - OP, OPIMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Wait states:** each cycle of `mem_ready`=0 in FETCH or MEM adds one cycle.
- **Memory handshake:**
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable while waiting.
  - Exactly one access completes per `mem_ready` cycle.
  - `mem_ready` outside FETCH and MEM is ignored.
- **Reset mid-operation:** `rst` asserted in any state, including mid-wait in MEM, forces FETCH and clears `instret` asynchronously. A pending store is abandoned and `mem_we` drops immediately.

## Test plan
- **ADDI, zero wait:** reset, opcode 0010011, `mem_ready`=1 always → state sequence 0,1,2,4,0; `reg_write`=1 only in WB with `wb_sel`=0; `instret`=1 after 4 cycles.
- **LW, 2 wait states per access:** opcode 0000011, `mem_ready` held low 2 cycles in each of FETCH and MEM → 9 cycles total; `mem_addr_sel`=1 and `mem_we`=0 in MEM; WB shows `wb_sel`=1.
- **Branches:** BEQ taken (`branch_taken`=1) → `pc_src`=1 in EXEC, 3 cycles, no `reg_write`. Not taken → `pc_src`=0.
- **JALR:** opcode 1100111 → WB shows `wb_sel`=2, `pc_src`=2, `pc_write`=1 and `reg_write`=1 together.
- **Halt:** ECALL 1110011 or illegal 1111111 → HALT after DECODE; `halted`=1; no `pc_write` and `instret` unchanged for 20 cycles; `rst` pulse → FETCH, `halted`=0.
- **Reset mid-store:** opcode 0100011, `rst` asserted in MEM with `mem_ready`=0 → `mem_we` drops in the same cycle; `state`=0; `instret`=0.

Source files
------------

// File: rtl/rv32_mc_control.sv
// rv32_mc_control
//   Multi-cycle control sequencer for an RV32I core. Each instruction steps
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a shared
//   single-port memory. The block drives the PC/IR/register-file enables,
//   the ALU operand-B select, the write-back select and the memory port.
//   SYSTEM and illegal opcodes park the sequencer in HALT until reset.
//
// Ports
//   clk, rst       core clock (rising edge), asynchronous active-high reset
//   opcode         IR[6:0], valid from DECODE onward (latched at DECODE)
//   branch_taken   branch comparator result, used in EXEC only
//   mem_ready      memory completes the current access this cycle
//   mem_req/mem_we/mem_addr_sel   memory request, write strobe, addr source
//   ir_write, pc_write, pc_src    IR load, PC load, next-PC source
//   alu_b_imm      ALU operand B: 1 = immediate, 0 = rs2
//   reg_write, wb_sel             register file write enable / source
//   state, halted, instret        debug state, halt flag, retired count
module rv32_mc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_b_imm,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_LOAD,
    CL_STORE, CL_OPIMM, CL_OP, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
  } class_e;

  function automatic class_e classify(input logic [6:0] op);
    case (op)
      7'b0110111: classify = CL_LUI;
      7'b0010111: classify = CL_AUIPC;
      7'b1101111: classify = CL_JAL;
      7'b1100111: classify = CL_JALR;
      7'b1100011: classify = CL_BRANCH;
      7'b0000011: classify = CL_LOAD;
      7'b0100011: classify = CL_STORE;
      7'b0010011: classify = CL_OPIMM;
      7'b0110011: classify = CL_OP;
      7'b0001111: classify = CL_FENCE;
      7'b1110011: classify = CL_SYSTEM;
      default:    classify = CL_ILLEGAL;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  opc_q, opc_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  class_e      cls_in, cls_q;

  // DECODE classifies the live IR bits; later states use only the latched copy.
  assign cls_in = classify(opcode);
  assign cls_q  = classify(opc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      opc_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_b_imm    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        opc_d = opcode;
        if (cls_in == CL_SYSTEM || cls_in == CL_ILLEGAL) state_d = ST_HALT;
        else                                             state_d = ST_EXEC;
      end

      ST_EXEC: begin
        alu_b_imm = !(cls_q == CL_OP || cls_q == CL_BRANCH);
        case (cls_q)
          CL_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_FENCE: begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_b_imm    = 1'b1;
        mem_we       = (cls_q == CL_STORE);
        if (mem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
        case (cls_q)
          CL_LOAD: wb_sel = 2'd1;
          CL_JAL: begin
            wb_sel = 2'd2;
            pc_src = 2'd1;
          end
          CL_JALR: begin
            wb_sel = 2'd2;
            pc_src = 2'd2;
          end
          CL_LUI:  wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_FETCH;
    endcase

    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv32_mc_control.sv
// Bench for rv32_mc_control: directed per-cycle rows with hand-computed
// expected outputs are pushed into a scoreboard queue; a negedge monitor
// pops each row and compares it with the DUT outputs.
module tb_rv32_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_b_imm, reg_write;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instret;

  rv32_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_b_imm(alu_b_imm), .reg_write(reg_write),
    .wb_sel(wb_sel), .state(state), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;
  // Driven on opcode after DECODE: later states must ignore the live input.
  localparam logic [6:0] G        = 7'b0000000;

  // ctl = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
  //        pc_src, alu_b_imm, reg_write, wb_sel, halted}
  typedef struct {
    string       nm;
    logic [14:0] ctl;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [14:0] got;
      mon_e = sb.pop_front();
      got = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
             pc_src, alu_b_imm, reg_write, wb_sel, halted};
      checks++;
      if (got !== mon_e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b exp %b", mon_e.nm, got, mon_e.ctl);
      end
      checks++;
      if (instret !== mon_e.inst) begin
        errors++;
        $display("FAIL %s instret got %0d exp %0d", mon_e.nm, instret, mon_e.inst);
      end
    end
  end

  // Drive one cycle of inputs (just after a rising edge), queue its expected
  // outputs, then advance to just after the next rising edge.
  task automatic step(input string nm, input logic r, input logic [6:0] op,
                      input logic mr, input logic bt, input logic [2:0] st,
                      input logic req, input logic we, input logic asel,
                      input logic irw, input logic pcw, input logic [1:0] pcs,
                      input logic bimm, input logic rw, input logic [1:0] wbs,
                      input logic hlt, input logic [31:0] inst);
    exp_t e;
    rst          = r;
    opcode       = op;
    mem_ready    = mr;
    branch_taken = bt;
    e.nm   = nm;
    e.ctl  = {st, req, we, asel, irw, pcw, pcs, bimm, rw, wbs, hlt};
    e.inst = inst;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string nm, input logic [6:0] op, input logic [31:0] inst);
    step(nm, 0, op, 1, 0, 3'd0, 1, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0, 0, inst);
  endtask

  task automatic fetch_wait(input string nm, input logic [6:0] op, input logic [31:0] inst);
    step(nm, 0, op, 0, 0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, inst);
  endtask

  task automatic decode(input string nm, input logic [6:0] op, input logic [31:0] inst);
    step(nm, 0, op, 1, 0, 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, inst);
  endtask

  task automatic reset_row(input string nm);
    step(nm, 1, G, 0, 0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_row("reset");

    // ADDI, zero wait: 0,1,2,4
    fetch_ok("addi_f", OP_OPIMM, 0);
    decode  ("addi_d", OP_OPIMM, 0);
    step("addi_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
    step("addi_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd0, 0, 0);

    // LW, two wait states in FETCH and in MEM: 9 cycles
    fetch_wait("lw_fw1", OP_LOAD, 1);
    fetch_wait("lw_fw2", OP_LOAD, 1);
    fetch_ok  ("lw_f",   OP_LOAD, 1);
    decode    ("lw_d",   OP_LOAD, 1);
    step("lw_x",   0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    step("lw_mw1", 0, G, 0, 0, 3'd3, 1, 0, 1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    step("lw_mw2", 0, G, 0, 0, 3'd3, 1, 0, 1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    step("lw_m",   0, G, 1, 0, 3'd3, 1, 0, 1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    step("lw_wb",  0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd1, 0, 1);

    // BEQ taken / not taken: 3 cycles, no reg_write
    fetch_ok("beqt_f", OP_BR, 2);
    decode  ("beqt_d", OP_BR, 2);
    step("beqt_x", 0, G, 1, 1, 3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 0, 2'd0, 0, 2);
    fetch_ok("beqn_f", OP_BR, 3);
    decode  ("beqn_d", OP_BR, 3);
    step("beqn_x", 0, G, 1, 0, 3'd2, 0, 0, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 3);

    // JALR
    fetch_ok("jalr_f", OP_JALR, 4);
    decode  ("jalr_d", OP_JALR, 4);
    step("jalr_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 4);
    step("jalr_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd2, 0, 1, 2'd2, 0, 4);

    // FENCE: 3 cycles
    fetch_ok("fence_f", OP_FENCE, 5);
    decode  ("fence_d", OP_FENCE, 5);
    step("fence_x", 0, G, 1, 1, 3'd2, 0, 0, 0, 0, 1, 2'd0, 1, 0, 2'd0, 0, 5);

    // LUI, JAL, AUIPC, OP
    fetch_ok("lui_f", OP_LUI, 6);
    decode  ("lui_d", OP_LUI, 6);
    step("lui_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 6);
    step("lui_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd3, 0, 6);
    fetch_ok("jal_f", OP_JAL, 7);
    decode  ("jal_d", OP_JAL, 7);
    step("jal_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 7);
    step("jal_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd1, 0, 1, 2'd2, 0, 7);
    fetch_ok("auipc_f", OP_AUIPC, 8);
    decode  ("auipc_d", OP_AUIPC, 8);
    step("auipc_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 8);
    step("auipc_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd0, 0, 8);
    fetch_ok("op_f", OP_OP, 9);
    decode  ("op_d", OP_OP, 9);
    step("op_x",  0, G, 1, 1, 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 9);
    step("op_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd0, 0, 9);

    // STORE, zero wait: 4 cycles
    fetch_ok("sw_f", OP_STORE, 10);
    decode  ("sw_d", OP_STORE, 10);
    step("sw_x", 0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 10);
    step("sw_m", 0, G, 1, 0, 3'd3, 1, 1, 1, 0, 1, 2'd0, 1, 0, 2'd0, 0, 10);

    // ECALL: HALT for 20 cycles, instret frozen at 11, then reset
    fetch_ok("ecall_f", OP_ECALL, 11);
    decode  ("ecall_d", OP_ECALL, 11);
    for (int i = 0; i < 20; i++)
      step("ecall_h", 0, G, 1, 1, 3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 11);
    reset_row("ecall_rst");

    // Illegal opcode
    fetch_ok("ill_f", OP_BAD, 0);
    decode  ("ill_d", OP_BAD, 0);
    for (int i = 0; i < 3; i++)
      step("ill_h", 0, G, 1, 0, 3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0);
    reset_row("ill_rst");

    // One ADDI so instret is nonzero, then reset in the middle of a store wait
    fetch_ok("addi2_f", OP_OPIMM, 0);
    decode  ("addi2_d", OP_OPIMM, 0);
    step("addi2_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
    step("addi2_wb", 0, G, 1, 0, 3'd4, 0, 0, 0, 0, 1, 2'd0, 0, 1, 2'd0, 0, 0);
    fetch_ok("swr_f", OP_STORE, 1);
    decode  ("swr_d", OP_STORE, 1);
    step("swr_x",  0, G, 1, 0, 3'd2, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    step("swr_mw", 0, G, 0, 0, 3'd3, 1, 1, 1, 0, 0, 2'd0, 1, 0, 2'd0, 0, 1);
    reset_row("swr_rst");
    fetch_ok("post_f", OP_OPIMM, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
